// File: rtl/clk_timer_pkg.sv
// Shared types and helpers for the clk_timer interval timer.
package clk_timer_pkg;

   typedef enum logic {StIdle, StCount} state_e;

   localparam int unsigned DefaultWidth = 8;

   // Increment that sticks at max_val; widths up to 32 bits.
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
      return (val >= max_val) ? max_val : val + 32'd1;
   endfunction

endpackage

// File: rtl/clk_timer_edge_sync.sv
// Optional input synchroniser (CLK_TIMER_SYNC_EN) followed by a rising-edge detector that emits
// a one-cycle pulse.
module clk_timer_edge_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sig_i,
   output logic pulse_o
);

   logic sig_s;
   logic prev_q, prev_d;

`ifdef CLK_TIMER_SYNC_EN
   logic [SYNC_STAGES-1:0] sync_q, sync_d;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], sig_i};
   assign sig_s  = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end
`else
   assign sig_s = sig_i;

   // SYNC_STAGES only sizes the synchroniser, which this build leaves out.
   if (SYNC_STAGES < 2) begin : g_no_sync
   end
`endif

   assign prev_d  = sig_s;
   assign pulse_o = sig_s & ~prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
      end
   end

endmodule

// File: rtl/clk_timer.sv
// Interval timer: clk cycles from a signal1 rising edge to the next signal2 rising edge.
// Define CLK_TIMER_SYNC_EN to place SYNC_STAGES-deep synchronisers in front of both detectors.
module clk_timer
   import clk_timer_pkg::*;
#(
   parameter int unsigned WIDTH       = DefaultWidth,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             signal1,
   input  logic             signal2,
   output logic [WIDTH-1:0] out
);

   localparam logic [WIDTH-1:0] MaxCount = '1;

   logic             rst_sync_q;
   logic             start, stop;
   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] count_inc;

   // Asserts with reset, releases on the first clk edge after reset goes high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_sync_q <= 1'b0;
      end else begin
         rst_sync_q <= 1'b1;
      end
   end

   clk_timer_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_start_edge (
      .clk_i  (clk),
      .rst_ni (rst_sync_q),
      .sig_i  (signal1),
      .pulse_o(start)
   );

   clk_timer_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_stop_edge (
      .clk_i  (clk),
      .rst_ni (rst_sync_q),
      .sig_i  (signal2),
      .pulse_o(stop)
   );

   assign count_inc = WIDTH'(sat_inc(32'(count_q), 32'(MaxCount)));

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      out_d   = out_q;
      unique case (state_q)
         StIdle: begin
            if (start && stop) begin
               out_d = '0;
            end else if (start) begin
               count_d = '0;
               state_d = StCount;
            end
         end
         StCount: begin
            // A start here is ignored: the first start of a measurement wins.
            if (stop) begin
               out_d   = count_inc;
               state_d = StIdle;
            end else begin
               count_d = count_inc;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_sync_q) begin
      if (!rst_sync_q) begin
         state_q <= StIdle;
         count_q <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         out_q   <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: tb/tb_clk_timer.sv
// Randomised self-checking bench for clk_timer against a cycle-stamp reference model.
module tb_clk_timer;

   localparam int unsigned Stages = 2;
`ifdef CLK_TIMER_SYNC_EN
   localparam int Lag = Stages;
`else
   localparam int Lag = 0;
`endif
   localparam int HistLen = 16384;

   logic       clk = 1'b0;
   logic       reset;
   logic       signal1;
   logic       signal2;
   logic [7:0] out;

   int checks   = 0;
   int failures = 0;

   // Reference model state: cycle stamps of detected rises.
   int         cyc       = 0;
   int         rst_cyc   = 0;
   int         start_cyc = 0;
   bit         busy      = 1'b0;
   bit         p1        = 1'b0;
   bit         p2        = 1'b0;
   logic [7:0] m_out     = 8'd0;
   logic [7:0] hist [HistLen];

   clk_timer #(
      .WIDTH      (8),
      .SYNC_STAGES(Stages)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .signal1(signal1),
      .signal2(signal2),
      .out    (out)
   );

   always #4 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 30)
            $display("FAIL %s: out=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // out = min(stop_cycle - start_cycle, 255), measured on sampled input rises.
   initial begin
      bit r1, r2;
      forever begin
         @(posedge clk);
         cyc++;
         if (!reset) begin
            busy    = 1'b0;
            m_out   = 8'd0;
            p1      = 1'b0;
            p2      = 1'b0;
            rst_cyc = cyc;
         end else begin
            r1 = signal1 && !p1;
            r2 = signal2 && !p2;
            p1 = signal1;
            p2 = signal2;
            if (busy) begin
               if (r2) begin
                  m_out = (cyc - start_cyc > 255) ? 8'd255 : 8'(cyc - start_cyc);
                  busy  = 1'b0;
               end
            end else if (r1) begin
               if (r2) begin
                  m_out = 8'd0;
               end else begin
                  busy      = 1'b1;
                  start_cyc = cyc;
               end
            end
         end
         if (cyc < HistLen) hist[cyc] = m_out;
      end
   end

   // Compare DUT against the model, delayed by the synchroniser lag, every cycle.
   initial begin
      logic [7:0] exp;
      forever begin
         @(negedge clk);
         if (cyc > 0 && cyc < HistLen) begin
            if (!reset || (cyc - Lag <= rst_cyc)) exp = 8'd0;
            else exp = hist[cyc - Lag];
            check("model", out, exp);
         end
      end
   end

   task automatic measure(input int gap, input logic [7:0] exp, input string name);
      signal1 = 1'b1;
      if (gap > 2) begin
         tick(2);
         signal1 = 1'b0;
         tick(gap - 2);
      end else begin
         tick(gap);
      end
      signal2 = 1'b1;
      tick(2);
      signal1 = 1'b0;
      signal2 = 1'b0;
      tick(10);
      check(name, out, exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      reset   = 1'b0;
      signal1 = 1'b0;
      signal2 = 1'b0;
      #20;
      check("reset_state", out, 8'd0);
      #10 reset = 1'b1;
      #90 signal1 = 1'b1;
      #40 signal1 = 1'b0;
      #50 signal2 = 1'b1;
      #40 signal2 = 1'b0;
      tick(10);
      check("basic_88ns", out, 8'd11);

      // signal2 rises while signal1 still high
      signal1 = 1'b1;
      tick(7);
      signal2 = 1'b1;
      tick(3);
      signal1 = 1'b0;
      signal2 = 1'b0;
      tick(10);
      check("overlap_7", out, 8'd7);
      measure(11, 8'd11, "second_11");

      signal2 = 1'b1;
      tick(2);
      signal2 = 1'b0;
      tick(10);
      check("stop_alone", out, 8'd11);

      signal1 = 1'b1;
      signal2 = 1'b1;
      tick(2);
      signal1 = 1'b0;
      signal2 = 1'b0;
      tick(10);
      check("same_cycle", out, 8'd0);

      // extra start during COUNT
      signal1 = 1'b1;
      tick(2);
      signal1 = 1'b0;
      tick(3);
      signal1 = 1'b1;
      tick(2);
      signal1 = 1'b0;
      tick(8);
      signal2 = 1'b1;
      tick(2);
      signal2 = 1'b0;
      tick(10);
      check("extra_start", out, 8'd15);

      // start coinciding with stop during COUNT
      signal1 = 1'b1;
      tick(2);
      signal1 = 1'b0;
      tick(7);
      signal1 = 1'b1;
      signal2 = 1'b1;
      tick(2);
      signal1 = 1'b0;
      signal2 = 1'b0;
      tick(10);
      check("start_with_stop", out, 8'd9);

      measure(1, 8'd1, "min_1");
      measure(254, 8'd254, "gap_254");
      measure(255, 8'd255, "gap_255");
      measure(300, 8'd255, "saturate_300");

      // reset mid-measurement
      signal1 = 1'b1;
      tick(2);
      signal1 = 1'b0;
      tick(18);
      #3 reset = 1'b0;
      #1 check("reset_abort", out, 8'd0);
      tick(3);
      reset = 1'b1;
      tick(5);
      signal2 = 1'b1;
      tick(2);
      signal2 = 1'b0;
      tick(10);
      check("stop_after_reset", out, 8'd0);
      measure(13, 8'd13, "after_reset_13");

      // dense random toggling
      for (int i = 0; i < 1500; i++) begin
         tick(1);
         if ($urandom_range(0, 5) == 0) signal1 = ~signal1;
         if ($urandom_range(0, 5) == 0) signal2 = ~signal2;
      end
      // sparse toggling exercises long intervals and saturation
      for (int i = 0; i < 2500; i++) begin
         tick(1);
         if ($urandom_range(0, 299) == 0) signal1 = ~signal1;
         if ($urandom_range(0, 199) == 0) signal2 = ~signal2;
      end
      signal1 = 1'b0;
      signal2 = 1'b0;
      tick(10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
